sprite_anim_src: RTL and testbench
==================================

Name: sprite_anim_src

Overview:
- Parametrised successor of the single fixed-size sprite source.
- Renders one sprite with configurable size, frame count, colour depth and pixel depth.
- Adds a writable palette, programmable animation rate and loop length, X/Y mirroring, a hit flag and a 2-cycle registered pipeline.
- Sits in the video slot chain; its output is chroma-key merged downstream like other sprite sources.

Parameters:
- CD, 12: colour depth of palette entries and of output.
- HW, 4: log2 sprite width (H_SIZE = 2**HW).
- VW, 4: log2 sprite height (V_SIZE = 2**VW).
- FW, 2: log2 number of animation frames stored.
- BPP, 2: bits per pixel code (1..4); palette has 2**BPP entries.
- KEY_COLOR, 0: colour output when transparent or out of region.
- Derived localparam ADDR = FW+VW+HW.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- x, y  in  11  current scan coordinate
- x0, y0  in  11  sprite origin (top-left)
- frame_sel  in  FW  manual frame id when auto_en=0
- auto_en  in  1  1 = frame id from animation counter
- ani_div  in  6  frames per animation step minus 1
- ani_last  in  FW  last frame index of animation loop
- mirror_x, mirror_y  in  1  horizontal / vertical flip
- we  in  1  sprite RAM write enable
- addr_w  in  ADDR  sprite RAM write address {frame, row, col}
- pixel_in  in  BPP  sprite RAM write data
- pal_we  in  1  palette write enable
- pal_addr  in  BPP  palette entry index
- pal_data  in  CD  palette entry colour
- sprite_rgb  out  CD  pixel colour, 2 cycles after x/y
- sprite_hit  out  1  1 = opaque sprite pixel, aligned with sprite_rgb

Behaviour:
- Relative coordinates:
  - xr = x - x0 and yr = y - y0, computed signed in 12 bits.
  - in_region = 0<=xr<H_SIZE && 0<=yr<V_SIZE.
  - Origin at 0 and origin near 2047 must not alias.
- Mirroring: col = mirror_x ? H_SIZE-1-xr[HW-1:0] : xr[HW-1:0]; row likewise with mirror_y.
- Read address = {sid, row, col}; sid = auto_en ? ani_reg : frame_sel.
- Sprite RAM: ADDR x BPP, synchronous read, not reset. Same-address read/write in one cycle returns old data.
- Pipeline:
  - Stage 1 registers the RAM code and in_region.
  - Stage 2 registers sprite_rgb and sprite_hit.
  - Latency is exactly 2 clocks for all inputs, including mirror_* and frame_sel.
- Palette:
  - 2**BPP x CD register file; all entries reset to 0.
  - Code 0 is always transparent regardless of entry 0 contents.
  - Palette write is visible to lookups on the cycle after pal_we; the same-cycle lookup uses the old value.
- Output rule: if !in_region_d1 or code==0 -> sprite_rgb=KEY_COLOR, hit=0; else sprite_rgb=palette[code], hit=1.
- Frame tick: x_d1==0 && x==1 && y==0, where x_d1 is a registered copy of x.
- Animation:
  - On tick: if c_reg>=ani_div, then c_reg<=0 and ani advances; else c_reg<=c_reg+1.
  - The >= comparison covers ani_div lowered mid-count.
  - ani advance: ani_reg>=ani_last -> 0, else +1. This also handles ani_last lowered below ani_reg.
  - Counters run regardless of auto_en. auto_en only selects sid.
- Reset (async assert, sync release): c_reg=0, ani_reg=0, x_d1=0, pipeline regs cleared, sprite_rgb=KEY_COLOR, sprite_hit=0, palette=0.
- Reset asserted mid-frame clears outputs immediately. Sprite RAM contents survive reset.

Optional Feature:
- Macro: SPRITE_ANIM_SCALE2X_EN.
- Defined: each texel is drawn 2x2.
  - Region becomes 0<=xr<2*H_SIZE, 0<=yr<2*V_SIZE.
  - col/row are taken from xr[HW:1], yr[VW:1] before mirroring.
  - Latency stays 2.
- Undefined: 1x mapping as above. Port list is identical either way.

Test Plan:
- Reset: hold reset_n=0 with x=y=x0=y0=0 -> sprite_rgb=KEY_COLOR, sprite_hit=0. After release, ani_reg=0.
- Latency/key:
  - Setup: palette[2]=12'hF00; RAM frame 0 row 0 col 3 = 2; x0=100, y0=50, frame_sel=0, auto_en=0.
  - x=103, y=50 -> 12'hF00, hit=1 exactly 2 clocks later.
  - x=99 or code 0 -> KEY_COLOR, hit=0.
- Mirror: same setup, mirror_x=1 -> pixel appears at x=100+12=112, y=50; x=103 shows col 12 data.
- Animation: auto_en=1, ani_div=2, ani_last=2, then generate 9 frame ticks -> ani_reg sequence 0,0,0,1,1,1,2,2,2,0 (one value per tick, advancing every 3rd tick, wrapping 2->0).
- Palette hazard: pal_we writes palette[2]=12'h0F0 on the same cycle the stage-2 lookup uses code 2 -> that pixel is 12'hF00, the next pixel is 12'h0F0.
- Boundary: x0=2040, x=0 -> xr negative, out of region, KEY_COLOR. With SPRITE_ANIM_SCALE2X_EN, x=x0+31 in region, x0+32 out.

Source files
------------

// File: rtl/sprite_anim_src.sv
// sprite_anim_src: animated, palette-based sprite source with a 2-cycle registered pipeline.
// Optional build macro SPRITE_ANIM_SCALE2X_EN: draws every texel as a 2x2 block.
module sprite_anim_src #(
  parameter int unsigned   CD        = 12,
  parameter int unsigned   HW        = 4,
  parameter int unsigned   VW        = 4,
  parameter int unsigned   FW        = 2,
  parameter int unsigned   BPP       = 2,
  parameter logic [CD-1:0] KEY_COLOR = '0,
  localparam int unsigned  ADDR      = FW + VW + HW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [10:0]     x,
  input  logic [10:0]     y,
  input  logic [10:0]     x0,
  input  logic [10:0]     y0,
  input  logic [FW-1:0]   frame_sel,
  input  logic            auto_en,
  input  logic [5:0]      ani_div,
  input  logic [FW-1:0]   ani_last,
  input  logic            mirror_x,
  input  logic            mirror_y,
  input  logic            we,
  input  logic [ADDR-1:0] addr_w,
  input  logic [BPP-1:0]  pixel_in,
  input  logic            pal_we,
  input  logic [BPP-1:0]  pal_addr,
  input  logic [CD-1:0]   pal_data,
  output logic [CD-1:0]   sprite_rgb,
  output logic            sprite_hit
);

  localparam int unsigned H_SIZE = 2 ** HW;
  localparam int unsigned V_SIZE = 2 ** VW;
  localparam int unsigned DEPTH  = 2 ** ADDR;
  localparam int unsigned PAL_N  = 2 ** BPP;

  logic [11:0]     xr;
  logic [11:0]     yr;
  logic            in_region;
  logic [HW-1:0]   tx;
  logic [VW-1:0]   ty;
  logic [HW-1:0]   col;
  logic [VW-1:0]   row;
  logic [FW-1:0]   sid;
  logic [ADDR-1:0] addr_r;

  logic [BPP-1:0]  mem [DEPTH];
  logic [CD-1:0]   pal [PAL_N];

  logic [BPP-1:0]  code_d1;
  logic            region_d1;

  logic [10:0]     x_d1;
  logic [5:0]      c_reg;
  logic [FW-1:0]   ani_reg;
  logic            tick;

  // Relative position (12-bit signed so origins near 2047 cannot alias), region test, texel address.
  always_comb begin
    xr = {1'b0, x} - {1'b0, x0};
    yr = {1'b0, y} - {1'b0, y0};
`ifdef SPRITE_ANIM_SCALE2X_EN
    in_region = !xr[11] && !yr[11] && (xr < 12'(2 * H_SIZE)) && (yr < 12'(2 * V_SIZE));
    tx        = xr[HW:1];
    ty        = yr[VW:1];
`else
    in_region = !xr[11] && !yr[11] && (xr < 12'(H_SIZE)) && (yr < 12'(V_SIZE));
    tx        = xr[HW-1:0];
    ty        = yr[VW-1:0];
`endif
    // SIZE-1-t equals bitwise inversion because sizes are powers of two
    col    = mirror_x ? ~tx : tx;
    row    = mirror_y ? ~ty : ty;
    sid    = auto_en ? ani_reg : frame_sel;
    addr_r = {sid, row, col};
  end

  // Sprite RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) mem[addr_w] <= pixel_in;
  end

  // Stage 1: registered RAM read (old data on same-address write) and region flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_d1   <= '0;
      region_d1 <= 1'b0;
    end else begin
      code_d1   <= mem[addr_r];
      region_d1 <= in_region;
    end
  end

  // Palette register file; a write lands after the edge, so the same-edge lookup sees the old entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < PAL_N; i++) pal[i] <= '0;
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  // Stage 2: colour lookup, code 0 is always transparent
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sprite_rgb <= KEY_COLOR;
      sprite_hit <= 1'b0;
    end else if (!region_d1 || (code_d1 == '0)) begin
      sprite_rgb <= KEY_COLOR;
      sprite_hit <= 1'b0;
    end else begin
      sprite_rgb <= pal[code_d1];
      sprite_hit <= 1'b1;
    end
  end

  assign tick = (x_d1 == 11'd0) && (x == 11'd1) && (y == 11'd0);

  // Animation: per-frame tick counter and looping frame index (>= tolerates limits lowered mid-run)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_d1    <= '0;
      c_reg   <= '0;
      ani_reg <= '0;
    end else begin
      x_d1 <= x;
      if (tick) begin
        if (c_reg >= ani_div) begin
          c_reg   <= '0;
          ani_reg <= (ani_reg >= ani_last) ? '0 : ani_reg + FW'(1);
        end else begin
          c_reg <= c_reg + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_anim_src.sv
// tb_sprite_anim_src: directed + randomized checks of sprite_anim_src against a behavioural model.
module tb_sprite_anim_src;

  localparam int H  = 16;
  localparam int V  = 16;
`ifdef SPRITE_ANIM_SCALE2X_EN
  localparam int SX = 2;
`else
  localparam int SX = 1;
`endif
  localparam logic [11:0] KEY = 12'h000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] x = '0, y = '0, x0 = '0, y0 = '0;
  logic [1:0]  frame_sel = '0;
  logic        auto_en = 1'b0;
  logic [5:0]  ani_div = '0;
  logic [1:0]  ani_last = '0;
  logic        mirror_x = 1'b0, mirror_y = 1'b0;
  logic        we = 1'b0;
  logic [9:0]  addr_w = '0;
  logic [1:0]  pixel_in = '0;
  logic        pal_we = 1'b0;
  logic [1:0]  pal_addr = '0;
  logic [11:0] pal_data = '0;
  logic [11:0] sprite_rgb;
  logic        sprite_hit;

  sprite_anim_src dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .x0(x0), .y0(y0),
    .frame_sel(frame_sel), .auto_en(auto_en), .ani_div(ani_div), .ani_last(ani_last),
    .mirror_x(mirror_x), .mirror_y(mirror_y), .we(we), .addr_w(addr_w), .pixel_in(pixel_in),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .sprite_rgb(sprite_rgb), .sprite_hit(sprite_hit)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [1:0]  m_ram [1024];
  logic [11:0] m_pal [4];
  int          n_ticks;
  logic [10:0] x_prev;
  bit          p_reg;
  logic [1:0]  p_code;

  int errors = 0;
  int checks = 0;

  // Pixel the current inputs address: region and stored code, from plain arithmetic
  task automatic model_pixel(output bit inr, output logic [1:0] code);
    int xr, yr, tx, ty, col, row, f;
    xr   = int'(x) - int'(x0);
    yr   = int'(y) - int'(y0);
    inr  = (xr >= 0) && (xr < H * SX) && (yr >= 0) && (yr < V * SX);
    code = 2'd0;
    if (inr) begin
      tx   = xr / SX;
      ty   = yr / SX;
      col  = mirror_x ? (H - 1 - tx) : tx;
      row  = mirror_y ? (V - 1 - ty) : ty;
      f    = auto_en ? ((n_ticks / (int'(ani_div) + 1)) % (int'(ani_last) + 1)) : int'(frame_sel);
      code = m_ram[(f * V + row) * H + col];
    end
  endtask

  task automatic chk_now(input string tag, input logic [11:0] er, input logic eh);
    checks++;
    assert (sprite_rgb === er) else begin
      errors++;
      $error("FAIL %s rgb got=%h exp=%h", tag, sprite_rgb, er);
    end
    checks++;
    assert (sprite_hit === eh) else begin
      errors++;
      $error("FAIL %s hit got=%b exp=%b", tag, sprite_hit, eh);
    end
  endtask

  // One clock: resolve the previous pixel, record this cycle's pixel, apply writes/tick, check output
  task automatic cyc();
    bit          inr;
    logic [1:0]  code;
    logic [11:0] er;
    logic        eh;
    if (!p_reg || p_code == 2'd0) begin er = KEY; eh = 1'b0; end
    else begin er = m_pal[p_code]; eh = 1'b1; end
    model_pixel(inr, code);
    if (pal_we) m_pal[pal_addr] = pal_data;
    if (we) m_ram[addr_w] = pixel_in;
    if (x_prev == 11'd0 && x == 11'd1 && y == 11'd0) n_ticks++;
    x_prev = x;
    p_reg  = inr;
    p_code = code;
    @(posedge clk);
    #1;
    checks++;
    assert (sprite_rgb === er) else begin
      errors++;
      $error("FAIL pipe rgb t=%0t got=%h exp=%h", $time, sprite_rgb, er);
    end
    checks++;
    assert (sprite_hit === eh) else begin
      errors++;
      $error("FAIL pipe hit t=%0t got=%b exp=%b", $time, sprite_hit, eh);
    end
  endtask

  task automatic rst_assert();
    we      = 1'b0;
    pal_we  = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) m_pal[i] = '0;
    n_ticks = 0;
    x_prev  = '0;
    p_reg   = 1'b0;
    p_code  = '0;
  endtask

  task automatic rst_release();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic pal_wr(input logic [1:0] a, input logic [11:0] d);
    pal_we = 1'b1; pal_addr = a; pal_data = d;
    cyc();
    pal_we = 1'b0;
  endtask

  task automatic ram_wr(input logic [9:0] a, input logic [1:0] d);
    we = 1'b1; addr_w = a; pixel_in = d;
    cyc();
    we = 1'b0;
  endtask

  int seq [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};

  initial begin
    // Reset state
    rst_assert();
    #12;
    chk_now("reset", KEY, 1'b0);
    rst_release();

    // Fill RAM with random codes, sprite placed away from the scan position
    x0 = 11'd100; y0 = 11'd50; x = 11'd0; y = 11'd0;
    for (int i = 0; i < 1024; i++) ram_wr(10'(i), 2'($urandom_range(0, 3)));
    pal_wr(2'd0, 12'hABC);
    pal_wr(2'd1, 12'h123);
    pal_wr(2'd2, 12'hF00);
    pal_wr(2'd3, 12'h456);
    ram_wr(10'd3, 2'd2);
    ram_wr(10'd4, 2'd0);
    ram_wr(10'd15, 2'd3);
    for (int f = 0; f < 4; f++) ram_wr(10'(f * 256), 2'(f + 1));

    // Latency and key colour
    x = 11'(100 + 3 * SX); y = 11'd50;
    cyc();
    chk_now("lat1", KEY, 1'b0);
    x = 11'd99;
    cyc();
    chk_now("lat2", 12'hF00, 1'b1);
    x = 11'(100 + 4 * SX);
    cyc();
    chk_now("left_out", KEY, 1'b0);
    x = 11'd0;
    cyc();
    chk_now("code0", KEY, 1'b0);

    // Horizontal mirror
    mirror_x = 1'b1;
    x = 11'(100 + 12 * SX);
    cyc();
    x = 11'(100 + 3 * SX);
    cyc();
    chk_now("mirror", 12'hF00, 1'b1);
    cyc();
    mirror_x = 1'b0;

    // Palette write on the same edge as the stage-2 lookup
    x = 11'(100 + 3 * SX);
    cyc();
    pal_wr(2'd2, 12'h0F0);
    chk_now("pal_old", 12'hF00, 1'b1);
    cyc();
    chk_now("pal_new", 12'h0F0, 1'b1);

    // Boundaries: far-right origin, and right edge of the sprite
    x0 = 11'd2040; x = 11'd0;
    cyc();
    x = 11'd2047;
    cyc();
    chk_now("wrap_neg", KEY, 1'b0);
    x0 = 11'd100;
    x = 11'(100 + H * SX - 1);
    cyc();
    x = 11'(100 + H * SX);
    cyc();
    chk_now("edge_in", 12'h456, 1'b1);
    cyc();
    chk_now("edge_out", KEY, 1'b0);

    // Animation sequence
    ani_div = 6'd2; ani_last = 2'd2; auto_en = 1'b1;
    x0 = 11'd0; y0 = 11'd0; x = 11'd5; y = 11'd5;
    rst_assert();
    rst_release();
    pal_wr(2'd1, 12'h111);
    pal_wr(2'd2, 12'h222);
    pal_wr(2'd3, 12'h333);
    for (int i = 0; i < 10; i++) begin
      x = 11'd0; y = 11'd0;
      cyc();
      x = 11'd1;
      cyc();
      chk_now($sformatf("anim%0d", i), 12'(12'h111 * (seq[i] + 1)), 1'b1);
    end

    // Reset mid-frame clears output at once; RAM keeps its contents
    ani_div = 6'($urandom_range(0, 3)); ani_last = 2'($urandom_range(0, 3));
    rst_assert();
    #2;
    chk_now("rst_mid", KEY, 1'b0);
    rst_release();
    auto_en = 1'b0; frame_sel = 2'd0; x = 11'd0; y = 11'd0;
    cyc();
    x = 11'd7;
    cyc();
    chk_now("ram_keep", 12'h000, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (x_prev == 11'd0 && $urandom_range(0, 1) == 1) x = 11'd1;
      else if ($urandom_range(0, 3) == 0) x = 11'd0;
      else x = 11'($urandom_range(0, 60));
      y         = ($urandom_range(0, 2) == 0) ? 11'd0 : 11'($urandom_range(0, 40));
      x0        = 11'($urandom_range(0, 20));
      y0        = 11'($urandom_range(0, 4));
      mirror_x  = 1'($urandom_range(0, 1));
      mirror_y  = 1'($urandom_range(0, 1));
      auto_en   = 1'($urandom_range(0, 1));
      frame_sel = 2'($urandom_range(0, 3));
      we        = ($urandom_range(0, 9) == 0);
      addr_w    = 10'($urandom_range(0, 1023));
      pixel_in  = 2'($urandom_range(0, 3));
      pal_we    = ($urandom_range(0, 9) == 0);
      pal_addr  = 2'($urandom_range(0, 3));
      pal_data  = 12'($urandom_range(0, 4095));
      cyc();
    end
    we = 1'b0; pal_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
